// File: rtl/sn74_serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - borrow_in.
// Operands are processed LSB first through one full-subtractor cell and a borrow flip-flop.
module sn74_serial_subtractor #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         borrow_in,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_sa;
  logic [N-1:0]   r_sb;
  logic [N-1:0]   r_sr;
  logic           r_br;
  logic [CW-1:0]  r_cnt;

  logic           w_d;
  logic           w_br_next;
  logic           w_last;
  logic [N-1:0]   w_sr_next;

  // Full-subtractor cell on the current LSBs
  assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  assign w_sr_next = {w_d, r_sr[N-1:1]};

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_last       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_last = (r_cnt == CW'(N - 1));
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sa       <= '0;
      r_sb       <= '0;
      r_sr       <= '0;
      r_br       <= 1'b0;
      r_cnt      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      busy    <= (w_state_next != S_IDLE);
      done    <= (w_state_next == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_br  <= borrow_in;
            r_sr  <= '0;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= w_sr_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          // Only the completed word is ever exposed on the outputs
          if (w_last) begin
            diff       <= w_sr_next;
            borrow_out <= w_br_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sn74_serial_subtractor.sv
// Scoreboard bench for sn74_serial_subtractor at N=4 and N=8.
`timescale 1ns/1ps
module tb_sn74_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       st4, bi4, st8, bi8;
  logic [3:0] a4, b4, d4;
  logic [7:0] a8, b8, d8;
  logic       bo4, busy4, done4, bo8, busy8, done8;

  int n_cmp = 0;
  int n_err = 0;
  int n_done4 = 0;
  logic [8:0] q4[$];
  logic [8:0] q8[$];

  always #5 clk = ~clk;

  sn74_serial_subtractor #(.N(4)) u_dut4 (
    .clk(clk), .reset(rst), .start(st4), .borrow_in(bi4), .a(a4), .b(b4),
    .diff(d4), .borrow_out(bo4), .busy(busy4), .done(done4));

  sn74_serial_subtractor #(.N(8)) u_dut8 (
    .clk(clk), .reset(rst), .start(st8), .borrow_in(bi8), .a(a8), .b(b8),
    .diff(d8), .borrow_out(bo8), .busy(busy8), .done(done8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: pop expected result on every done pulse
  always @(negedge clk) begin
    logic [8:0] e;
    if (done4 === 1'b1) begin
      n_done4++;
      if (q4.size() == 0) check("done4_unexpected", 32'(1), 32'(0));
      else begin
        e = q4.pop_front();
        check("res4", 32'({bo4, d4}), 32'(e[4:0]));
      end
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) check("done8_unexpected", 32'(1), 32'(0));
      else begin
        e = q8.pop_front();
        check("res8", 32'({bo8, d8}), 32'(e));
      end
    end
  end

  task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic bi, input bit push);
    logic [4:0] r;
    @(negedge clk);
    a4 = a; b4 = b; bi4 = bi; st4 = 1'b1;
    r = {1'b0, a} - {1'b0, b} - 5'(bi);
    if (push) q4.push_back(9'(r));
    @(negedge clk);
    st4 = 1'b0;
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    logic [8:0] r;
    @(negedge clk);
    a8 = a; b8 = b; bi8 = bi; st8 = 1'b1;
    r = {1'b0, a} - {1'b0, b} - 9'(bi);
    q8.push_back(r);
    @(negedge clk);
    st8 = 1'b0;
  endtask

  task automatic wait_idle4();
    for (int i = 0; i < 30 && busy4 !== 1'b0; i++) @(negedge clk);
    check("idle4_timeout", 32'(busy4), 32'(0));
  endtask

  task automatic wait_idle8();
    for (int i = 0; i < 30 && busy8 !== 1'b0; i++) @(negedge clk);
    check("idle8_timeout", 32'(busy8), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nd;
    logic [15:0] x, y;
    logic [7:0] lo;
    logic xb;
    logic [16:0] full;

    rst = 1'b1; st4 = 1'b0; bi4 = 1'b0; a4 = '0; b4 = '0;
    st8 = 1'b0; bi8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("rst_diff4", 32'(d4), 32'(0));
    check("rst_bo4", 32'(bo4), 32'(0));
    check("rst_busy4", 32'(busy4), 32'(0));
    check("rst_done4", 32'(done4), 32'(0));
    check("rst_diff8", 32'(d8), 32'(0));
    rst = 1'b0;

    // 9-5: done exactly in the cycle after E4, busy drops after E5
    go4(4'd9, 4'd5, 1'b0, 1'b1);
    check("t1_busy", 32'(busy4), 32'(1));
    repeat (3) @(negedge clk);
    check("t1_done_early", 32'(done4), 32'(0));
    @(negedge clk);
    check("t1_done", 32'(done4), 32'(1));
    check("t1_busy_done", 32'(busy4), 32'(1));
    check("t1_diff", 32'(d4), 32'(4));
    @(negedge clk);
    check("t1_busy_end", 32'(busy4), 32'(0));
    check("t1_done_end", 32'(done4), 32'(0));

    go4(4'd0, 4'd0, 1'b1, 1'b1);
    wait_idle4();
    check("t2_allones", 32'({bo4, d4}), 32'(5'b11111));
    go4(4'd3, 4'd7, 1'b0, 1'b1);
    wait_idle4();
    check("t2_diff", 32'({bo4, d4}), 32'(5'b11100));

    // Outputs hold the previous result during shifting
    go4(4'd8, 4'd8, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold", 32'(d4), 32'(12));
    end
    wait_idle4();
    check("t3_zero", 32'({bo4, d4}), 32'(0));

    // Start and operand changes while busy are ignored, incl. start in DONE
    nd = n_done4;
    go4(4'd6, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    st4 = 1'b1; a4 = 4'd15; b4 = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a4 = 4'($urandom); b4 = 4'($urandom); bi4 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    st4 = 1'b0;
    check("t4_busy_after", 32'(busy4), 32'(0));
    @(negedge clk);
    check("t4_no_restart", 32'(busy4), 32'(0));
    check("t4_one_done", 32'(n_done4 - nd), 32'(1));
    check("t4_diff", 32'({bo4, d4}), 32'(4));

    // Reset mid-operation aborts with zeroed outputs
    go4(4'd10, 4'd3, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_diff", 32'(d4), 32'(0));
    check("t5_bo", 32'(bo4), 32'(0));
    check("t5_busy", 32'(busy4), 32'(0));
    check("t5_done", 32'(done4), 32'(0));
    repeat (8) @(negedge clk);
    check("t5_idle", 32'(busy4), 32'(0));
    go4(4'd10, 4'd3, 1'b0, 1'b1);
    wait_idle4();
    check("t5_fresh", 32'({bo4, d4}), 32'(7));

    // N=8 timing and basic values
    go8(8'd200, 8'd55, 1'b0);
    repeat (7) @(negedge clk);
    check("t6_done_early", 32'(done8), 32'(0));
    @(negedge clk);
    check("t6_done", 32'(done8), 32'(1));
    wait_idle8();
    check("t6_diff", 32'({bo8, d8}), 32'({1'b0, 8'd145}));
    go8(8'd55, 8'd200, 1'b0);
    wait_idle8();
    check("t6_neg", 32'({bo8, d8}), 32'({1'b1, 8'd111}));
    go8(8'd255, 8'd0, 1'b0);
    wait_idle8();
    check("t6_max", 32'({bo8, d8}), 32'({1'b0, 8'd255}));

    // 16-bit subtraction chained through two 8-bit words
    for (int i = 0; i < 10; i++) begin
      x = 16'($urandom); y = 16'($urandom); xb = 1'($urandom_range(0, 1));
      go8(x[7:0], y[7:0], xb);
      wait_idle8();
      lo = d8;
      go8(x[15:8], y[15:8], bo8);
      wait_idle8();
      full = {1'b0, x} - {1'b0, y} - 17'(xb);
      check("chain16", 32'({bo8, d8, lo}), 32'(full));
    end

    // Random operands, checked by the scoreboard
    for (int i = 0; i < 40; i++) begin
      go8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      wait_idle8();
    end

    repeat (3) @(negedge clk);
    check("q4_drained", 32'(q4.size()), 32'(0));
    check("q8_drained", 32'(q8.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
